if_stage: RTL and testbench

Instruction-fetch stage of the five-stage RISC-V core. Owns the program counter, drives the instruction-memory address, and loads the IF/ID pipeline register whose instruction word feeds decode and is watched by the bench for end-of-program (all-zero word). Handles start gating, hazard stalls, branch redirect/flush and halt detection.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_id_reg.sv | 54 +++++
 rtl/if_stage.sv | 99 +++++++++
 tb/tb_if_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the five-stage RISC-V core.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0,x0,0 -- the bubble word; never zero because zero means halt
   localparam logic [XLEN-1:0] DEFAULT_NOP_WORD = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold (neither control) and flush (bubble) controls.
module if_id_reg
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] instr_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;

   // Next contents: flush inserts a bubble keeping the old PC, load captures, else hold
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (flush_i) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (load_i) begin
         pc_d    = pc_i;
         instr_d = instr_i;
         valid_d = 1'b1;
      end
   end

   // Pipeline register storage
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_q    <= '0;
         instr_q <= NOP_WORD;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, fetch state machine and IF/ID register.
module if_stage
   import cpu_pkg::*;
#(
   parameter int unsigned     IMEM_DEPTH = 256,
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter logic [XLEN-1:0] NOP_WORD   = DEFAULT_NOP_WORD
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_data_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_2_o,
   output logic [XLEN-1:0] instruction_2_o,
   output logic            valid_2_o,
   output logic            halt_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] fetch_word;
   logic            in_range;
   logic            fetch_go;
   logic            if_load;
   logic            if_flush;

   // Fetched word: addresses beyond the memory read as zero (and so halt)
   always_comb begin
      in_range   = ({2'b00, pc_q[XLEN-1:2]} < IMEM_DEPTH);
      fetch_word = in_range ? imem_data_i : '0;
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: IDLE leaves on start, a loaded zero word halts, HALT is sticky
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     state_d = RUN;
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
      if (if_load && (fetch_word == '0)) state_d = HALT;
   end

   // Output decode: IDLE with start fetches on the same edge; stall outranks redirect
   always_comb begin
      fetch_go = 1'b0;
      halt_o   = 1'b0;
      case (state_q)
         IDLE, RUN: fetch_go = start_i;
         HALT:      halt_o   = 1'b1;
         default:   fetch_go = 1'b0;
      endcase
      if_flush = fetch_go & ~stall_i &  branch_taken_i;
      if_load  = fetch_go & ~stall_i & ~branch_taken_i;
   end

   // Next PC: redirect, sequential advance (not on the halting word), or hold
   always_comb begin
      pc_d = pc_q;
      if (if_flush)                             pc_d = branch_target_i;
      else if (if_load && (fetch_word != '0))   pc_d = pc_q + 32'd4;
   end

   // Program counter register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   if_id_reg #(
      .NOP_WORD (NOP_WORD)
   ) u_if_id_reg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (if_load),
      .flush_i (if_flush),
      .pc_i    (pc_q),
      .instr_i (fetch_word),
      .pc_o    (pc_2_o),
      .instr_o (instruction_2_o),
      .valid_o (valid_2_o)
   );

   assign pc_o        = pc_q;
   assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small expected-result scoreboard.
module tb_if_stage;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] pc2;
      logic [31:0] instr;
      logic        valid;
      logic        halt;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stall_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_i;
   logic [31:0] pc_o;
   logic [31:0] pc_2_o;
   logic [31:0] instruction_2_o;
   logic        valid_2_o;
   logic        halt_o;

   logic [31:0] mem [0:255];
   exp_t        sb [$];
   int          checks = 0;
   int          errors = 0;

   // Memory aliases above 0x3FF on purpose: the DUT itself must zero out-of-range fetches
   assign imem_data_i = mem[imem_addr_o[9:2]];

   always #5 clk_i = ~clk_i;

   if_stage #(
      .IMEM_DEPTH (256),
      .RESET_PC   (32'h0),
      .NOP_WORD   (32'h0000_0013)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .start_i         (start_i),
      .stall_i         (stall_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .imem_addr_o     (imem_addr_o),
      .imem_data_i     (imem_data_i),
      .pc_o            (pc_o),
      .pc_2_o          (pc_2_o),
      .instruction_2_o (instruction_2_o),
      .valid_2_o       (valid_2_o),
      .halt_o          (halt_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input exp_t e);
      chk({e.tag, ".pc"},    pc_o,            e.pc);
      chk({e.tag, ".addr"},  imem_addr_o,     e.pc);
      chk({e.tag, ".pc2"},   pc_2_o,          e.pc2);
      chk({e.tag, ".instr"}, instruction_2_o, e.instr);
      chk({e.tag, ".valid"}, {31'b0, valid_2_o}, {31'b0, e.valid});
      chk({e.tag, ".halt"},  {31'b0, halt_o},    {31'b0, e.halt});
   endtask

   // Drive one cycle of inputs, expect the given registered state after the edge
   task automatic step(input string tag, input logic st, input logic stl, input logic br,
                       input logic [31:0] tgt, input logic [31:0] e_pc, input logic [31:0] e_pc2,
                       input logic [31:0] e_instr, input logic e_valid, input logic e_halt);
      exp_t e;
      e = '{tag, e_pc, e_pc2, e_instr, e_valid, e_halt};
      sb.push_back(e);
      start_i         = st;
      stall_i         = stl;
      branch_taken_i  = br;
      branch_target_i = tgt;
      @(posedge clk_i);
      #1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed empty-scoreboard expected entry", tag);
      end else begin
         e = sb.pop_front();
         chk_all(e);
      end
   endtask

   task automatic do_reset();
      start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
      rst_i = 1'b0;
      #3;
      rst_i = 1'b1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   initial begin
      rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = '0;
      clear_mem();
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      mem[2] = 32'h0000_0000;
      #12;
      rst_i = 1'b1;
      #1;
      chk_all('{"reset", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0});

      // Basic program run, stall, halt
      step("idle_hold", 0, 0, 0, 32'h0,  32'h0, 32'h0, 32'h13,        0, 0);
      step("fetch0",    1, 0, 0, 32'h0,  32'h4, 32'h0, 32'h0050_0093, 1, 0);
      step("fetch1",    1, 0, 0, 32'h0,  32'h8, 32'h4, 32'h00A0_0113, 1, 0);
      step("stall1",    1, 1, 0, 32'h0,  32'h8, 32'h4, 32'h00A0_0113, 1, 0);
      step("stall2",    1, 1, 0, 32'h0,  32'h8, 32'h4, 32'h00A0_0113, 1, 0);
      step("halt",      1, 0, 0, 32'h0,  32'h8, 32'h8, 32'h0,         1, 1);
      step("frozen",    1, 0, 1, 32'h80, 32'h8, 32'h8, 32'h0,         1, 1);
      step("frozen2",   1, 0, 0, 32'h0,  32'h8, 32'h8, 32'h0,         1, 1);

      // Asynchronous reset between edges mid-run
      do_reset();
      step("rB_fetch0", 1, 0, 0, 32'h0, 32'h4, 32'h0, 32'h0050_0093, 1, 0);
      #2;
      rst_i = 1'b0;
      #1;
      chk_all('{"async_rst", 32'h0, 32'h0, 32'h13, 1'b0, 1'b0});
      #2;
      rst_i = 1'b1;
      step("rB_idle",   0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h13, 0, 0);
      step("rB_idle2",  0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h13, 0, 0);

      // Redirect discarding a zero word; stall beats branch
      clear_mem();
      mem[0]  = 32'h0050_0093;
      mem[16] = 32'h0010_0093;
      mem[17] = 32'h0020_0113;
      do_reset();
      step("c_fetch0",  1, 0, 0, 32'h0,  32'h4,  32'h0,  32'h0050_0093, 1, 0);
      step("c_branch",  1, 0, 1, 32'h40, 32'h40, 32'h0,  32'h13,        0, 0);
      step("c_target",  1, 0, 0, 32'h0,  32'h44, 32'h40, 32'h0010_0093, 1, 0);
      step("c_stallbr", 1, 1, 1, 32'h80, 32'h44, 32'h40, 32'h0010_0093, 1, 0);
      step("c_resume",  1, 0, 0, 32'h0,  32'h48, 32'h44, 32'h0020_0113, 1, 0);
      step("c_pause",   0, 0, 1, 32'h80, 32'h48, 32'h44, 32'h0020_0113, 1, 0);
      step("c_halt",    1, 0, 0, 32'h0,  32'h48, 32'h48, 32'h0,         1, 1);

      // Running off the end of instruction memory
      clear_mem();
      mem[0]   = 32'h0050_0093;
      mem[255] = 32'h0000_0093;
      do_reset();
      step("d_branch",  1, 0, 1, 32'h3FC, 32'h3FC, 32'h0,   32'h13,   0, 0);
      step("d_last",    1, 0, 0, 32'h0,   32'h400, 32'h3FC, 32'h0093, 1, 0);
      step("d_oob",     1, 0, 0, 32'h0,   32'h400, 32'h400, 32'h0,    1, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed no-finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
